// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencing for load-use, branch/jump redirects and multi-cycle MDU ops.
// Define HAZARD_PERF_EN to add saturating stall/flush perf counters.
module pipeline_hazard_ctrl #(
    parameter int REG_ADDR_W   = 5,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic                  id_jump,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mem_read,
    input  logic                  ex_branch_taken,
    input  logic                  ex_mdu_start,
    input  logic                  mdu_done,
    output logic                  pc_write,
    output logic                  ID_write,
    output logic                  IF_flush,
    output logic                  id_ex_flush,
    output logic                  id_ex_write,
    output logic                  ex_mem_flush,
    output logic [1:0]            state_o
`ifdef HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
`endif
);
    localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    typedef enum logic [1:0] {RUN = 2'd0, MDU_BUSY = 2'd1, REDIRECT = 2'd2} state_e;

    state_e         state_q, state_d;
    logic [FCW-1:0] cnt_q, cnt_d;
    logic           load_use;

    assign load_use = ex_mem_read && (ex_rd != '0) &&
                      ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));
    assign state_o  = state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pc_write     = 1'b1;
        ID_write     = 1'b1;
        IF_flush     = 1'b0;
        id_ex_flush  = 1'b0;
        id_ex_write  = 1'b1;
        ex_mem_flush = 1'b0;
        case (state_q)
            RUN: begin
                if (ex_branch_taken) begin
                    IF_flush    = 1'b1;
                    id_ex_flush = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_d = REDIRECT;
                        cnt_d   = FCW'(FLUSH_CYCLES - 1);
                    end
                end else if (ex_mdu_start) begin
                    // start+done together lets the result advance with no stall
                    if (!mdu_done) begin
                        pc_write     = 1'b0;
                        ID_write     = 1'b0;
                        id_ex_write  = 1'b0;
                        ex_mem_flush = 1'b1;
                        state_d      = MDU_BUSY;
                    end
                end else if (load_use) begin
                    pc_write    = 1'b0;
                    ID_write    = 1'b0;
                    id_ex_flush = 1'b1;
                end else if (id_jump) begin
                    IF_flush = 1'b1;
                end
            end
            MDU_BUSY: begin
                if (mdu_done) begin
                    state_d = RUN;
                end else begin
                    pc_write     = 1'b0;
                    ID_write     = 1'b0;
                    id_ex_write  = 1'b0;
                    ex_mem_flush = 1'b1;
                end
            end
            REDIRECT: begin
                IF_flush    = 1'b1;
                id_ex_flush = 1'b1;
                cnt_d       = cnt_q - FCW'(1);
                if (cnt_q == FCW'(1)) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase
        if (rst) begin
            pc_write     = 1'b0;
            ID_write     = 1'b0;
            IF_flush     = 1'b0;
            id_ex_flush  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_flush = 1'b0;
        end
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!pc_write && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (IF_flush && flush_cnt != '1)
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed vector table plus hand sequences for async reset and perf counters.
module tb_pipeline_hazard_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_use_rs1, id_use_rs2, id_jump, ex_mem_read, ex_branch_taken, ex_mdu_start, mdu_done;
    logic       pc_write, ID_write, IF_flush, id_ex_flush, id_ex_write, ex_mem_flush;
    logic [1:0] state_o;
`ifdef HAZARD_PERF_EN
    logic [3:0] stall_cnt, flush_cnt;
`endif

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.REG_ADDR_W(5), .FLUSH_CYCLES(3), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_jump(id_jump), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
        .ex_branch_taken(ex_branch_taken), .ex_mdu_start(ex_mdu_start), .mdu_done(mdu_done),
        .pc_write(pc_write), .ID_write(ID_write), .IF_flush(IF_flush),
        .id_ex_flush(id_ex_flush), .id_ex_write(id_ex_write), .ex_mem_flush(ex_mem_flush),
        .state_o(state_o)
`ifdef HAZARD_PERF_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    // output order: {pc_write, ID_write, IF_flush, id_ex_flush, id_ex_write, ex_mem_flush}
    localparam logic [5:0] ZRO = 6'b000000;
    localparam logic [5:0] DEF = 6'b110010;
    localparam logic [5:0] LU  = 6'b000110;
    localparam logic [5:0] BR  = 6'b111110;
    localparam logic [5:0] JMP = 6'b111010;
    localparam logic [5:0] MDU = 6'b000001;

    typedef struct {
        logic [4:0] rs1, rs2, rd;
        logic       u1, u2, jmp, mr, br, ms, md;
        logic [5:0] exp;
        logic [1:0] est;
    } vec_t;

    vec_t vecs[26];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic vec_t mk(input logic [4:0] rs1, rs2, rd,
                                input logic u1, u2, jmp, mr, br, ms, md,
                                input logic [5:0] e, input logic [1:0] s);
        vec_t v;
        v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
        v.u1 = u1; v.u2 = u2; v.jmp = jmp; v.mr = mr; v.br = br; v.ms = ms; v.md = md;
        v.exp = e; v.est = s;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        id_rs1 = v.rs1; id_rs2 = v.rs2; ex_rd = v.rd;
        id_use_rs1 = v.u1; id_use_rs2 = v.u2; id_jump = v.jmp; ex_mem_read = v.mr;
        ex_branch_taken = v.br; ex_mdu_start = v.ms; mdu_done = v.md;
    endtask

    task automatic check(input string nm, input logic [5:0] e, input logic [1:0] s);
        logic [5:0] got;
        got = {pc_write, ID_write, IF_flush, id_ex_flush, id_ex_write, ex_mem_flush};
        n_vec++;
        if (got !== e || state_o !== s) begin
            n_err++;
            $display("FAIL %s: got outs=%b state=%0d, want outs=%b state=%0d", nm, got, state_o, e, s);
        end
    endtask

    vec_t idle;

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, 0);
        //                 rs1 rs2 rd u1 u2 jp mr br ms md  exp  st
        vecs[0]  = mk(0,  0,  0, 0, 0, 0, 0, 0, 0, 0, DEF, 0);
        vecs[1]  = mk(0,  5,  5, 0, 1, 0, 1, 0, 0, 0, LU,  0);
        vecs[2]  = mk(0,  0,  0, 0, 0, 0, 0, 0, 0, 0, DEF, 0);
        vecs[3]  = mk(0,  0,  0, 0, 1, 0, 1, 0, 0, 0, DEF, 0);
        vecs[4]  = mk(7,  3,  7, 1, 1, 0, 1, 0, 0, 0, LU,  0);
        vecs[5]  = mk(7,  3,  7, 0, 1, 0, 1, 0, 0, 0, DEF, 0);
        vecs[6]  = mk(0,  0,  0, 0, 0, 1, 0, 0, 0, 0, JMP, 0);
        vecs[7]  = mk(0,  0,  0, 0, 0, 0, 0, 1, 0, 0, BR,  0);
        vecs[8]  = mk(0,  0,  0, 0, 0, 0, 0, 0, 0, 0, BR,  2);
        vecs[9]  = mk(0,  5,  5, 0, 1, 1, 1, 0, 0, 0, BR,  2);
        vecs[10] = mk(0,  0,  0, 0, 0, 0, 0, 0, 0, 0, DEF, 0);
        vecs[11] = mk(0,  0,  0, 0, 0, 0, 0, 0, 1, 0, MDU, 0);
        vecs[12] = mk(0,  0,  0, 0, 0, 0, 0, 0, 0, 0, MDU, 1);
        vecs[13] = mk(9,  0,  9, 1, 0, 0, 1, 1, 0, 0, MDU, 1);
        vecs[14] = mk(0,  0,  0, 0, 0, 1, 0, 0, 0, 0, MDU, 1);
        vecs[15] = mk(0,  0,  0, 0, 0, 0, 0, 0, 0, 1, DEF, 1);
        vecs[16] = mk(0,  0,  0, 0, 0, 0, 0, 0, 0, 0, DEF, 0);
        vecs[17] = mk(0,  0,  0, 0, 0, 0, 0, 0, 1, 1, DEF, 0);
        vecs[18] = mk(0,  0,  0, 0, 0, 0, 0, 0, 0, 0, DEF, 0);
        vecs[19] = mk(4,  0,  4, 1, 0, 1, 1, 1, 0, 0, BR,  0);
        vecs[20] = mk(0,  0,  0, 0, 0, 0, 0, 0, 0, 0, BR,  2);
        vecs[21] = mk(0,  0,  0, 0, 0, 0, 0, 0, 0, 0, BR,  2);
        vecs[22] = mk(0,  0,  0, 0, 0, 0, 0, 0, 0, 0, DEF, 0);
        vecs[23] = mk(6,  6,  6, 1, 1, 0, 1, 0, 1, 0, MDU, 0);
        vecs[24] = mk(0,  0,  0, 0, 0, 0, 0, 0, 0, 1, DEF, 1);
        vecs[25] = mk(31, 0, 31, 1, 0, 0, 1, 0, 0, 0, LU,  0);

        rst = 1'b1;
        drive(idle);
        @(negedge clk);
        check("reset_hold", ZRO, 0);
        rst = 1'b0;
        #1 check("reset_release", DEF, 0);

        for (int i = 0; i < 26; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #1 check($sformatf("vec%0d", i), vecs[i].exp, vecs[i].est);
        end

        // async reset arriving mid-cycle while a branch is being taken
        @(negedge clk);
        drive(idle);
        ex_branch_taken = 1'b1;
        #1 check("br_pre_rst", BR, 0);
        rst = 1'b1;
        #1 check("rst_async_br", ZRO, 0);
        @(negedge clk);
        rst = 1'b0;
        drive(idle);
        #1 check("after_rst_br", DEF, 0);

        // async reset abandons a redirect in progress
        @(negedge clk);
        ex_branch_taken = 1'b1;
        @(negedge clk);
        drive(idle);
        #1 check("redirect_live", BR, 2);
        rst = 1'b1;
        #1 check("rst_async_redir", ZRO, 0);
        @(negedge clk);
        rst = 1'b0;
        #1 check("after_rst_redir", DEF, 0);
        @(negedge clk);
        #1 check("stays_run", DEF, 0);

`ifdef HAZARD_PERF_EN
        @(negedge clk);
        rst = 1'b1;
        #1 rst = 1'b0;
        n_vec++;
        if (stall_cnt !== 4'd0 || flush_cnt !== 4'd0) begin
            n_err++;
            $display("FAIL perf_reset: got stall=%0d flush=%0d, want 0 0", stall_cnt, flush_cnt);
        end
        ex_mdu_start = 1'b1;
        @(negedge clk);
        ex_mdu_start = 1'b0;
        for (int i = 0; i < 19; i++) @(negedge clk);
        mdu_done = 1'b1;
        #1;
        n_vec++;
        if (stall_cnt !== 4'd15 || flush_cnt !== 4'd0) begin
            n_err++;
            $display("FAIL perf_sat: got stall=%0d flush=%0d, want 15 0", stall_cnt, flush_cnt);
        end
        @(negedge clk);
        mdu_done = 1'b0;
        ex_branch_taken = 1'b1;
        @(negedge clk);
        ex_branch_taken = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_vec++;
        if (flush_cnt !== 4'd3 || stall_cnt !== 4'd15) begin
            n_err++;
            $display("FAIL perf_flush: got stall=%0d flush=%0d, want 15 3", stall_cnt, flush_cnt);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
